// File: rtl/pc_unit_pkg.sv
// Shared types for the program-counter unit: FSM states and the
// per-cycle action chosen by the RUN-state priority encoder.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_HALT,
    ACT_RET,
    ACT_CALL,
    ACT_ABS,
    ACT_REL,
    ACT_INC
  } action_t;

  // Exactly one action per RUN cycle; earlier terms win.
  function automatic action_t pick_action(
    input logic stall,
    input logic halt,
    input logic ret,
    input logic call,
    input logic branch_abs,
    input logic rel_taken
  );
    if (stall)           return ACT_HOLD;
    else if (halt)       return ACT_HALT;
    else if (ret)        return ACT_RET;
    else if (call)       return ACT_CALL;
    else if (branch_abs) return ACT_ABS;
    else if (rel_taken)  return ACT_REL;
    else                 return ACT_INC;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack: a push when full overwrites the oldest
// entry while the occupancy count saturates at RAS_DEPTH.
module ret_stack #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_up;
  logic [PTR_W-1:0] ptr_down;
  logic [PTR_W:0]   count;

  assign ptr_up   = top_ptr + PTR_W'(1);
  assign ptr_down = top_ptr - PTR_W'(1);
  assign top      = mem[top_ptr];
  assign full     = (count == (PTR_W+1)'(RAS_DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= ptr_up;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      top_ptr <= ptr_down;
      count   <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset && !clear && push) mem[ptr_up] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with program select, absolute/relative branches,
// call/return via ret_stack, stall, halt and sticky stack-error flags.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned NUM_PROGS = 3,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = {10'd0, 10'd0, 10'd0},
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned SEL_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_abs,
  input  logic             branch_rel_en,
  input  logic             alu_flag,
  input  logic             call,
  input  logic             ret,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             running,
  output logic             done,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  state_t          state, next_state;
  action_t         action;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] base;
  logic            push, pop, clear;
  logic            set_ovf, set_unf;
  logic [PC_W-1:0] stk_top;
  logic            stk_full, stk_empty;

  assign pc_inc = prog_ctr + PC_W'(1);

  ret_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .Reset     (Reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Out-of-range selections fall back to program 0.
  always_comb begin
    base = PROG_BASE[PC_W-1:0];
    for (int unsigned k = 0; k < NUM_PROGS; k++) begin
      if (prog_sel == SEL_W'(k)) base = PROG_BASE[k*PC_W +: PC_W];
    end
  end

  always_comb begin
    next_state = state;
    pc_next    = prog_ctr;
    action     = ACT_HOLD;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (Start) begin
      next_state = ST_ARMED;
      pc_next    = base;
      clear      = 1'b1;
    end else begin
      case (state)
        ST_ARMED: next_state = ST_RUN;
        ST_RUN: begin
          action = pick_action(stall, halt, ret, call, branch_abs,
                               branch_rel_en && alu_flag);
          case (action)
            ACT_HOLD: ;
            ACT_HALT: next_state = ST_HALT;
            ACT_RET: begin
              if (!stk_empty) begin
                pc_next = stk_top;
                pop     = 1'b1;
              end else begin
                pc_next = pc_inc;
                set_unf = 1'b1;
              end
            end
            ACT_CALL: begin
              push    = 1'b1;
              pc_next = target;
              set_ovf = stk_full;
            end
            ACT_ABS:  pc_next = target;
            ACT_REL:  pc_next = prog_ctr + target;
            ACT_INC:  pc_next = pc_inc;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      prog_ctr      <= '0;
      running       <= 1'b0;
      done          <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state    <= next_state;
      prog_ctr <= pc_next;
      running  <= (next_state == ST_RUN);
      done     <= (next_state == ST_HALT);
      if (clear) begin
        ras_overflow  <= 1'b0;
        ras_underflow <= 1'b0;
      end else begin
        if (set_ovf) ras_overflow  <= 1'b1;
        if (set_unf) ras_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model queues the expected
// outputs for each driven cycle, compared after the following clock edge.
module tb_pc_unit;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned NUM_PROGS = 3;
  localparam int unsigned RAS_DEPTH = 4;
  localparam logic [NUM_PROGS*PC_W-1:0] BASES = {10'h120, 10'h080, 10'h040};

  logic            clk = 1'b0;
  logic            Reset, Start;
  logic [1:0]      prog_sel;
  logic            stall, halt, branch_abs, branch_rel_en, alu_flag, call, ret;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] prog_ctr;
  logic            running, done, ras_overflow, ras_underflow;

  pc_unit #(
    .PC_W      (PC_W),
    .NUM_PROGS (NUM_PROGS),
    .PROG_BASE (BASES),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .Start         (Start),
    .prog_sel      (prog_sel),
    .stall         (stall),
    .halt          (halt),
    .branch_abs    (branch_abs),
    .branch_rel_en (branch_rel_en),
    .alu_flag      (alu_flag),
    .call          (call),
    .ret           (ret),
    .target        (target),
    .prog_ctr      (prog_ctr),
    .running       (running),
    .done          (done),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            running;
    logic            done;
    logic            ovf;
    logic            unf;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: 0=IDLE 1=ARMED 2=RUN 3=HALT; stack oldest at front.
  int              m_state = 0;
  logic [PC_W-1:0] m_pc    = '0;
  logic [PC_W-1:0] m_stk[$];
  logic            m_ovf   = 1'b0;
  logic            m_unf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PC_W-1:0] base_of(input logic [1:0] sel);
    case (sel)
      2'd1:    return 10'h080;
      2'd2:    return 10'h120;
      default: return 10'h040;
    endcase
  endfunction

  task automatic model_step();
    obs_t e;
    if (Reset) begin
      m_state = 0; m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (Start) begin
      m_state = 1; m_pc = base_of(prog_sel); m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2 && !stall) begin
      if (halt) m_state = 3;
      else if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_unf = 1; m_pc = m_pc + 10'd1; end
      end else if (call) begin
        if (m_stk.size() == RAS_DEPTH) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
        m_stk.push_back(m_pc + 10'd1);
        m_pc = target;
      end else if (branch_abs) m_pc = target;
      else if (branch_rel_en && alu_flag) m_pc = m_pc + target;
      else m_pc = m_pc + 10'd1;
    end
    e.pc = m_pc; e.running = (m_state == 2); e.done = (m_state == 3);
    e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic step();
    obs_t e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("prog_ctr", 32'(prog_ctr), 32'(e.pc));
    check("running", 32'(running), 32'(e.running));
    check("done", 32'(done), 32'(e.done));
    check("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
    check("ras_underflow", 32'(ras_underflow), 32'(e.unf));
  endtask

  task automatic quiet();
    Reset = 0; Start = 0; prog_sel = 0; stall = 0; halt = 0; branch_abs = 0;
    branch_rel_en = 0; alu_flag = 0; call = 0; ret = 0; target = '0;
  endtask

  task automatic jump(input logic [PC_W-1:0] t);
    quiet(); branch_abs = 1; target = t; step(); quiet();
  endtask

  task automatic do_call(input logic [PC_W-1:0] t);
    quiet(); call = 1; target = t; step(); quiet();
  endtask

  task automatic do_ret();
    quiet(); ret = 1; step(); quiet();
  endtask

  task automatic arm(input logic [1:0] sel);
    quiet(); Start = 1; prog_sel = sel; step(); quiet(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    quiet();
    Reset = 1; step(); step();
    check("reset_pc", 32'(prog_ctr), 32'h0);

    // Reset mid-RUN.
    arm(2'd0);
    jump(10'h155);
    check("pre_reset_pc", 32'(prog_ctr), 32'h155);
    Reset = 1; step(); quiet();
    check("reset_mid_run_pc", 32'(prog_ctr), 32'h0);
    check("reset_mid_run_running", 32'(running), 32'h0);

    // Start held 3 cycles, then run from base.
    Start = 1; prog_sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("armed_pc", 32'(prog_ctr), 32'h120);
    end
    quiet(); step();
    check("first_run_pc", 32'(prog_ctr), 32'h120);
    step(); check("run_inc1", 32'(prog_ctr), 32'h121);
    step(); check("run_inc2", 32'(prog_ctr), 32'h122);

    // Relative branches and wrap.
    jump(10'h010);
    branch_rel_en = 1; alu_flag = 1; target = 10'h3FE; step(); quiet();
    check("rel_taken", 32'(prog_ctr), 32'h00E);
    jump(10'h010);
    branch_rel_en = 1; alu_flag = 0; target = 10'h3FE; step(); quiet();
    check("rel_not_taken", 32'(prog_ctr), 32'h011);
    jump(10'h3FF);
    step(); check("pc_wrap", 32'(prog_ctr), 32'h000);

    // Nested calls, returns, underflow.
    jump(10'h020);
    do_call(10'h100);
    for (int i = 0; i < 5; i++) step();
    check("pc_before_call2", 32'(prog_ctr), 32'h105);
    do_call(10'h200);
    do_ret(); check("ret_inner", 32'(prog_ctr), 32'h106);
    do_ret(); check("ret_outer", 32'(prog_ctr), 32'h021);
    do_ret();
    check("underflow_flag", 32'(ras_underflow), 32'h1);
    check("underflow_pc", 32'(prog_ctr), 32'h022);

    // Overflow with RAS_DEPTH=4; re-arm clears flags.
    arm(2'd1);
    check("rearm_clears_unf", 32'(ras_underflow), 32'h0);
    do_call(10'h300); do_call(10'h310); do_call(10'h320); do_call(10'h330);
    check("no_overflow_at_depth", 32'(ras_overflow), 32'h0);
    do_call(10'h340);
    check("overflow_flag", 32'(ras_overflow), 32'h1);
    do_ret(); check("ovf_ret5", 32'(prog_ctr), 32'h331);
    do_ret(); check("ovf_ret4", 32'(prog_ctr), 32'h321);
    do_ret(); check("ovf_ret3", 32'(prog_ctr), 32'h311);
    do_ret(); check("ovf_ret2", 32'(prog_ctr), 32'h301);
    do_ret(); check("ovf_underflow", 32'(ras_underflow), 32'h1);
    check("ovf_underflow_pc", 32'(prog_ctr), 32'h302);

    // Priority: ret over call and branch_abs; ret right after call.
    do_call(10'h050);
    call = 1; ret = 1; branch_abs = 1; target = 10'h3AA; step(); quiet();
    check("ret_wins", 32'(prog_ctr), 32'h303);

    // Stall freezes, including halt and call; then halt.
    stall = 1; halt = 1; step(); quiet();
    check("stall_halt_pc", 32'(prog_ctr), 32'h303);
    check("stall_halt_running", 32'(running), 32'h1);
    stall = 1; call = 1; target = 10'h111; step(); quiet();
    halt = 1; step(); quiet();
    check("halt_done", 32'(done), 32'h1);
    check("halt_pc", 32'(prog_ctr), 32'h303);
    branch_abs = 1; target = 10'h0AA; step(); step(); quiet();
    check("halt_hold_pc", 32'(prog_ctr), 32'h303);
    Start = 1; prog_sel = 2'd3; step(); quiet();
    check("rearm_clears_done", 32'(done), 32'h0);
    check("sel_out_of_range", 32'(prog_ctr), 32'h040);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      Reset         = ($urandom_range(63) == 0);
      Start         = ($urandom_range(23) == 0);
      prog_sel      = 2'($urandom_range(3));
      stall         = ($urandom_range(7) == 0);
      halt          = ($urandom_range(19) == 0);
      ret           = ($urandom_range(3) == 0);
      call          = ($urandom_range(3) == 0);
      branch_abs    = ($urandom_range(3) == 0);
      branch_rel_en = ($urandom_range(2) == 0);
      alu_flag      = ($urandom_range(1) == 0);
      target        = 10'($urandom_range(1023));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the CSE141L core: it holds the fetch address and supplies it to instruction memory each cycle. It supports multiple packed programs selected at start, absolute and conditional relative branches, and call/return through a bounded return-address stack. It also supports stall, halt and program-done signalling. It sits between the control decoder/ALU flag output and the instruction ROM address port.

## Interface
Parameters:
- PC_W, default 10: program-counter width; all address arithmetic is modulo 2^PC_W.
- NUM_PROGS, default 3: number of selectable programs.
- PROG_BASE, default {10'd0, 10'd0, 10'd0}: packed NUM_PROGS×PC_W vector; slice k is the start address of program k.
- RAS_DEPTH, default 4: return-address stack entries (≥2, power of two).

Ports:
- clk  in  1  clock; all state changes on rising edge only.
- Reset  in  1  reset, synchronous, active-high.
- Start  in  1  arm/select program; hold PC at base while high.
- prog_sel  in  $clog2(NUM_PROGS)  program index sampled while Start high.
- stall  in  1  freeze PC and stack this cycle.
- halt  in  1  current instruction is the program's terminal instruction.
- branch_abs  in  1  unconditional jump to target.
- branch_rel_en  in  1  relative jump if alu_flag.
- alu_flag  in  1  condition from ALU.
- call  in  1  push PC+1, jump to target.
- ret  in  1  pop return address into PC.
- target  in  PC_W  absolute address, or signed two's-complement offset for relative branches.
- prog_ctr  out  PC_W  fetch address.
- running  out  1  state is RUN.
- done  out  1  state is HALT.
- ras_overflow  out  1  sticky; a call occurred with the stack full.
- ras_underflow  out  1  sticky; a ret occurred with the stack empty.

## Operation
- States: IDLE, ARMED, RUN, HALT.
- Reset (any state, any inputs): state=IDLE, prog_ctr=0, stack empty, running=0, done=0, both sticky flags 0.
- Start=1, any non-reset state: next state ARMED, prog_ctr <= PROG_BASE[prog_sel]. Start overrides every other control.
  - Entering ARMED clears the stack and both sticky flags.
  - prog_sel ≥ NUM_PROGS selects program 0.
- ARMED, Start=0: next state RUN, prog_ctr unchanged. The first RUN cycle fetches the base address.
- IDLE, Start=0: hold.
- HALT, Start=0: hold; prog_ctr frozen on the halting instruction's address.
- RUN update priority, highest first; exactly one action per cycle:
  1. stall: hold everything, including halt.
  2. halt: next state HALT, PC holds.
  3. ret: if the stack is non-empty, prog_ctr <= top and pop. If empty, set ras_underflow and prog_ctr <= prog_ctr+1.
  4. call: push prog_ctr+1, prog_ctr <= target. If the stack is full, overwrite the oldest entry (circular), keep depth at RAS_DEPTH and set ras_overflow.
  5. branch_abs: prog_ctr <= target.
  6. branch_rel_en && alu_flag: prog_ctr <= prog_ctr + target, modulo 2^PC_W.
  7. otherwise prog_ctr <= prog_ctr+1; wraps from 2^PC_W−1 to 0.
- Lower-priority requests asserted in the same cycle are ignored, not queued.
- Control inputs other than Start are ignored outside RUN.

## Timing
- Single-cycle: controls sampled at edge N take effect in prog_ctr after edge N; no combinational path from inputs to prog_ctr.
- running and done are registered and decode the current state.
- Return-address push and pop complete in the same edge as the PC update. A ret in the cycle after a call returns the just-pushed address.
- Sticky flags assert on the edge of the offending op and hold until Reset or ARMED entry.

## Structure
- Package pc_unit_pkg: state enum (IDLE/ARMED/RUN/HALT) and the action-select enum for the priority encoder (HOLD, HALT, RET, CALL, ABS, REL, INC).
- Sub-module ret_stack, parametrised on PC_W and RAS_DEPTH:
  - circular buffer with a top pointer and an occupancy count;
  - push, pop and clear inputs; top, full and empty outputs.
- pc_unit holds the FSM, the priority mux and the sticky flags.

## Test plan
- Reset mid-RUN at PC=0x155 → next cycle prog_ctr=0, IDLE, flags 0. Start with prog_sel=2, PROG_BASE[2]=0x120, held 3 cycles → prog_ctr=0x120 throughout. Start drops → RUN; sequence 0x120, 0x121, 0x122.
- From PC=0x010: target=0x3FE (−2), branch_rel_en=1, alu_flag=1 → 0x00E. alu_flag=0 → 0x011. From PC=0x3FF, increment → 0x000.
- Nested calls at PC 0x020→0x100, 0x105→0x200, then two rets → 0x106, then 0x021; stack empty. A third ret → ras_underflow=1, PC increments.
- RAS_DEPTH=4: five calls → ras_overflow=1. Five rets return the 5th, 4th, 3rd and 2nd return addresses, then underflow on the fifth ret.
- Same cycle call+ret+branch_abs → ret wins. stall with halt → PC frozen, still RUN. halt alone → done=1, PC frozen. Start then re-arms and clears done.
